// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall unit: FSM state encoding,
// mult/div counter width, hazard term bundle and the register-match helper.
package hazard_stall_unit_pkg;

    localparam int MD_CTR_W = 6;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } hsu_state_e;

    typedef struct packed {
        logic load_use;
        logic br_alu;
        logic br_load_ex;
        logic br_load_mem;
        logic md_use;
    } hazard_t;

    // Register r0 is hard-wired zero, so a write to it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] rw,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       use_rt);
        return (rw != 5'd0) && ((rw == rs) || (use_rt && (rw == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_md_busy_ctr.sv
// Mult/div occupancy down-counter: loads MD_LAT-1 on md_start (also when busy),
// counts down to zero; md_busy is asserted while the count is nonzero.
module md_busy_ctr #(
    parameter int MD_LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic md_start,
    output logic md_busy
);
    import hazard_stall_unit_pkg::*;

    localparam logic [MD_CTR_W-1:0] LOAD_VAL = MD_CTR_W'(MD_LAT - 1);

    logic [MD_CTR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (md_start) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard detection and stall/flush control. Optional stall statistics
// counter is built when HAZARD_STATS_EN is defined.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   RUN   | normal operation; stall only from live hazard terms
//   HOLD  | one forced stall cycle after a branch met a load in EX
module hazard_stall_unit #(
    parameter int MD_LAT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs_reg,
    input  logic [4:0] rt_reg,
    input  logic       useRt_ID,
    input  logic       Branch_ID,
    input  logic       Jump_ID,
    input  logic       BranchTaken_ID,
    input  logic       mdUse_ID,
    input  logic [4:0] rw_IDEx,
    input  logic       RegWr_IDEx,
    input  logic       MemRead_IDEx,
    input  logic [4:0] rw_ExMem,
    input  logic       MemRead_ExMem,
    input  logic       md_start,
    output logic       PCWr,
    output logic       IFID_Wr,
    output logic       IDEx_Bubble,
    output logic       IFID_Flush,
    output logic       md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);
    import hazard_stall_unit_pkg::*;

    hsu_state_e state_q;
    hsu_state_e state_d;
    hazard_t    hz;
    logic       match_ex;
    logic       match_mem;
    logic       hold_force;
    logic       stall;

    md_busy_ctr #(
        .MD_LAT (MD_LAT)
    ) u_md_busy_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .md_start (md_start),
        .md_busy  (md_busy)
    );

    assign match_ex  = reg_match(rw_IDEx,  rs_reg, rt_reg, useRt_ID);
    assign match_mem = reg_match(rw_ExMem, rs_reg, rt_reg, useRt_ID);

    always_comb begin
        hz             = '0;
        hz.load_use    = MemRead_IDEx && match_ex;
        hz.br_alu      = Branch_ID && RegWr_IDEx && !MemRead_IDEx && match_ex;
        hz.br_load_ex  = Branch_ID && MemRead_IDEx && match_ex;
        hz.br_load_mem = Branch_ID && MemRead_ExMem && match_mem;
        hz.md_use      = mdUse_ID && md_busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // HOLD leaves unconditionally; a fresh branch-on-load is only recognised from RUN.
    always_comb begin
        state_d    = state_q;
        hold_force = 1'b0;
        case (state_q)
            RUN: begin
                if (hz.br_load_ex) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                hold_force = 1'b1;
                state_d    = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    assign stall       = (|hz) || hold_force;
    assign PCWr        = !stall;
    assign IFID_Wr     = !stall;
    assign IDEx_Bubble = stall;
    assign IFID_Flush  = (Jump_ID || (Branch_ID && BranchTaken_ID)) && !stall;

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios plus random
// traffic checked against a rule-level reference model.
module tb_hazard_stall_unit;

    localparam int MD_LAT = 32;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic       br;
        logic       jmp;
        logic       taken;
        logic       md_use;
        logic [4:0] rw_ex;
        logic       regwr_ex;
        logic       mr_ex;
        logic [4:0] rw_mem;
        logic       mr_mem;
        logic       md_start;
    } stim_t;

    typedef struct packed {
        logic pcwr;
        logic ifidwr;
        logic bubble;
        logic flush;
        logic busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs_reg, rt_reg, rw_IDEx, rw_ExMem;
    logic       useRt_ID, Branch_ID, Jump_ID, BranchTaken_ID, mdUse_ID;
    logic       RegWr_IDEx, MemRead_IDEx, MemRead_ExMem, md_start;
    logic       PCWr, IFID_Wr, IDEx_Bubble, IFID_Flush, md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    longint      m_stall_cnt;
`endif

    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;
    exp_t sb[$];

    // reference model state
    stim_t cur;
    int    m_md_left;
    bit    m_hold_next;

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    hazard_stall_unit #(.MD_LAT(MD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs_reg(rs_reg), .rt_reg(rt_reg), .useRt_ID(useRt_ID),
        .Branch_ID(Branch_ID), .Jump_ID(Jump_ID), .BranchTaken_ID(BranchTaken_ID),
        .mdUse_ID(mdUse_ID), .rw_IDEx(rw_IDEx), .RegWr_IDEx(RegWr_IDEx),
        .MemRead_IDEx(MemRead_IDEx), .rw_ExMem(rw_ExMem), .MemRead_ExMem(MemRead_ExMem),
        .md_start(md_start), .PCWr(PCWr), .IFID_Wr(IFID_Wr), .IDEx_Bubble(IDEx_Bubble),
        .IFID_Flush(IFID_Flush), .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    function automatic bit depends(input logic [4:0] rw, input stim_t s);
        return (rw != 0) && (rw == s.rs || (s.use_rt && rw == s.rt));
    endfunction

    function automatic bit enters_hold(input stim_t s);
        return !m_hold_next && s.br && s.mr_ex && depends(s.rw_ex, s);
    endfunction

    function automatic exp_t expect_for(input stim_t s);
        exp_t e;
        bit   stall;
        stall = m_hold_next
              || (s.mr_ex && depends(s.rw_ex, s))
              || (s.br && s.regwr_ex && depends(s.rw_ex, s))
              || (s.br && s.mr_mem && depends(s.rw_mem, s))
              || (s.md_use && m_md_left > 0);
        e.pcwr   = !stall;
        e.ifidwr = !stall;
        e.bubble = stall;
        e.flush  = (s.jmp || (s.br && s.taken)) && !stall;
        e.busy   = (m_md_left > 0);
        return e;
    endfunction

    task automatic apply(input stim_t s);
        rs_reg = s.rs; rt_reg = s.rt; useRt_ID = s.use_rt;
        Branch_ID = s.br; Jump_ID = s.jmp; BranchTaken_ID = s.taken; mdUse_ID = s.md_use;
        rw_IDEx = s.rw_ex; RegWr_IDEx = s.regwr_ex; MemRead_IDEx = s.mr_ex;
        rw_ExMem = s.rw_mem; MemRead_ExMem = s.mr_mem; md_start = s.md_start;
    endtask

    task automatic model_clock();
        bit go_hold;
        go_hold = enters_hold(cur);
`ifdef HAZARD_STATS_EN
        if (!expect_for(cur).pcwr) m_stall_cnt++;
`endif
        if (cur.md_start) m_md_left = MD_LAT - 1;
        else if (m_md_left > 0) m_md_left--;
        m_hold_next = go_hold;
    endtask

    task automatic step(input stim_t s);
        @(posedge clk);
        model_clock();
        #1;
        cur = s;
        apply(s);
        sb.push_back(expect_for(s));
    endtask

    task automatic check_now(input string name, input exp_t want);
        exp_t got;
        got = '{PCWr, IFID_Wr, IDEx_Bubble, IFID_Flush, md_busy};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got pcwr/ifidwr/bubble/flush/busy=%b want %b", name, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        cur = '0;
        apply(cur);
        m_md_left = 0;
        m_hold_next = 0;
`ifdef HAZARD_STATS_EN
        m_stall_cnt = 0;
`endif
        #1;
        check_now("reset_immediate", 5'b11000);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    // monitor: outputs are presented every cycle, compare mid-cycle
    initial begin
        exp_t e, got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = '{PCWr, IFID_Wr, IDEx_Bubble, IFID_Flush, md_busy};
                tests++;
                if (got !== e) begin
                    fails++;
                    $display("FAIL outputs cycle %0d: got pcwr/ifidwr/bubble/flush/busy=%b want %b",
                             cycle, got, e);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        rst_n = 1'b0;
        cur = '0;
        apply(cur);
        m_md_left = 0;
        m_hold_next = 0;
`ifdef HAZARD_STATS_EN
        m_stall_cnt = 0;
`endif
        #2;
        check_now("reset_values", 5'b11000);
        do_reset();
        repeat (3) step('0);

        // load-use on rs
        s = '0; s.mr_ex = 1; s.rw_ex = 5; s.rs = 5;
        step(s); step('0); step('0);

        // branch on load in EX, taken: RUN stall, HOLD stall, then flush
        s = '0; s.br = 1; s.taken = 1; s.rs = 7; s.mr_ex = 1; s.rw_ex = 7;
        step(s);
        s = '0; s.br = 1; s.taken = 1; s.rs = 7; s.mr_mem = 1; s.rw_mem = 7;
        step(s);
        s = '0; s.br = 1; s.taken = 1; s.rs = 7;
        step(s); step('0);

        // register zero never hazards
        s = '0; s.mr_ex = 1; s.rw_ex = 0; s.rs = 0; s.br = 1; s.mr_mem = 1;
        step(s);

        // branch on ALU result through rt
        s = '0; s.br = 1; s.use_rt = 1; s.rt = 9; s.rs = 3; s.regwr_ex = 1; s.rw_ex = 9;
        step(s);
        s.use_rt = 0;
        step(s);

        // mult/div occupancy with continuous use
        s = '0; s.md_start = 1;
        step(s);
        s = '0; s.md_use = 1;
        repeat (MD_LAT + 2) step(s);

        // jump coinciding with load-use
        s = '0; s.jmp = 1; s.mr_ex = 1; s.rw_ex = 4; s.rs = 4;
        step(s);
        s = '0; s.jmp = 1;
        step(s); step('0);

        // reset during HOLD with md busy
        s = '0; s.md_start = 1;
        step(s);
        s = '0; s.br = 1; s.rs = 2; s.mr_ex = 1; s.rw_ex = 2;
        step(s);
        s = '0; s.md_use = 1;
        step(s);
        do_reset();
        s = '0; s.md_use = 1;
        step(s); step('0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.use_rt   = 1'($urandom_range(0, 1));
            s.br       = ($urandom_range(0, 99) < 35);
            s.jmp      = ($urandom_range(0, 99) < 15);
            s.taken    = 1'($urandom_range(0, 1));
            s.md_use   = ($urandom_range(0, 99) < 30);
            s.rw_ex    = 5'($urandom_range(0, 3));
            s.regwr_ex = 1'($urandom_range(0, 1));
            s.mr_ex    = ($urandom_range(0, 99) < 30);
            s.rw_mem   = 5'($urandom_range(0, 3));
            s.mr_mem   = ($urandom_range(0, 99) < 30);
            s.md_start = ($urandom_range(0, 99) < 3);
            step(s);
            if (i == 1500) do_reset();
        end
        step('0);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
`ifdef HAZARD_STATS_EN
        @(posedge clk);
        model_clock();
        #1;
        tests++;
        if (longint'(stall_cycles) != m_stall_cnt) begin
            fails++;
            $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, m_stall_cnt);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
